fpu_op_sequencer: RTL and testbench

- Sits between the memory-mapped FPU register block and the FPU arithmetic units.
- Accepts one operation command at a time over a valid/ready handshake, latches the operands and rounding mode, and issues a one-cycle start pulse to the selected unit.
- Waits for that unit's done pulse, or a timeout, then returns one response carrying the result, the exception flags and an error code.
- Enforces a single operation in flight and rejects malformed opcodes without issuing them.

---
 rtl/fpu_ctrl_pkg.sv | 33 +++
 rtl/fpu_op_sequencer_if.sv | 48 ++++
 rtl/fpu_op_timer.sv | 32 +++
 rtl/rvdffe.sv | 26 ++
 rtl/fpu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 295 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared types and helpers for the FPU control path: sequencer states,
// response error codes and the unit-select legality check.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  // Op vector bits below this index are modifiers; bits from here up are the one-hot unit select.
  localparam int OP_SEL_LSB = 2;

  // Widest unit-select field the legality helper can judge; callers zero-extend into it.
  localparam int MAX_SEL_BITS = 32;

  typedef logic [MAX_SEL_BITS-1:0] sel_t;

  // True when exactly one unit-select bit is set.
  function automatic logic onehot_legal(input sel_t sel);
    sel_t w_dec;
    w_dec = sel - sel_t'(1);
    return (sel != '0) && ((sel & w_dec) == '0);
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Bundle of the command, issue, unit-completion and response signals of the
// FPU op sequencer. The sequencer takes the slave view; the register block
// and arithmetic units together take the master view.
interface fpu_op_sequencer_if #(
  parameter int NUM_OPS = 13
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [NUM_OPS-1:0] cmd_op;
  logic [31:0]        cmd_a;
  logic [31:0]        cmd_b;
  logic [31:0]        cmd_c;
  logic [2:0]         cmd_frm;
  logic               flush;

  logic [NUM_OPS-1:0] issue_valids;
  logic [31:0]        issue_a;
  logic [31:0]        issue_b;
  logic [31:0]        issue_c;
  logic [2:0]         issue_frm;

  logic [NUM_OPS-1:0] unit_done;
  logic [31:0]        unit_result;
  logic [4:0]         unit_exc;

  logic               rsp_valid;
  logic [NUM_OPS-1:0] rsp_op;
  logic [31:0]        rsp_result;
  logic [4:0]         rsp_exc;
  logic [1:0]         rsp_err;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_frm, flush,
    output unit_done, unit_result, unit_exc,
    input  cmd_ready, issue_valids, issue_a, issue_b, issue_c, issue_frm,
    input  rsp_valid, rsp_op, rsp_result, rsp_exc, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_frm, flush,
    input  unit_done, unit_result, unit_exc,
    output cmd_ready, issue_valids, issue_a, issue_b, issue_c, issue_frm,
    output rsp_valid, rsp_op, rsp_result, rsp_exc, rsp_err, busy
  );

endinterface

// File: rtl/fpu_op_timer.sv
// Saturating wait counter for the sequencer timeout. Clear reloads zero,
// enable counts up, and tc flags the last allowed wait cycle. The count
// stops at TIMEOUT_CYCLES-1 instead of wrapping.
module fpu_op_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_l,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Clear has priority over counting; counting stops at the terminal value.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TC_VAL)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/rvdffe.sv
// Enable flop cell: captures din when en is high, otherwise holds.
// Synchronous active-low reset clears the stored value.
module rvdffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_q;

  // Capture on enable, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= din;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU op sequencer: accepts one command, pulses the selected unit, waits for
// its done (or a timeout) and returns a single response. Malformed op vectors
// are answered with ILLEGAL without touching any unit.
module fpu_op_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_OPS        = 13,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst_l,
  fpu_op_sequencer_if.slave bus
);

  localparam int SEL_W = NUM_OPS - OP_SEL_LSB;
  localparam int CMD_W = NUM_OPS + 3 * 32 + 3;
  localparam int RSP_W = NUM_OPS + 32 + 5 + 2;

  state_e             r_state;
  state_e             w_next;

  logic [CMD_W-1:0]   r_cmd;
  logic [RSP_W-1:0]   r_rsp;

  logic [NUM_OPS-1:0] w_lat_op;
  logic [31:0]        w_lat_a;
  logic [31:0]        w_lat_b;
  logic [31:0]        w_lat_c;
  logic [2:0]         w_lat_frm;

  sel_t               w_cmd_sel;
  logic               w_legal;
  logic               w_accept;
  logic               w_done_hit;
  logic               w_tc;
  logic               w_unused_done;

  logic               w_rsp_load;
  logic [NUM_OPS-1:0] w_rsp_op;
  logic [31:0]        w_rsp_result;
  logic [4:0]         w_rsp_exc;
  logic [1:0]         w_rsp_err;

  logic               w_cmd_ready;
  logic [NUM_OPS-1:0] w_issue_valids;
  logic               w_rsp_valid;
  logic               w_busy;
  logic               w_timer_clr;
  logic               w_timer_en;

  // Zero-extend the incoming unit-select field so the shared legality helper can judge it.
  always_comb begin
    w_cmd_sel              = '0;
    w_cmd_sel[SEL_W-1:0]   = bus.cmd_op[NUM_OPS-1:OP_SEL_LSB];
  end

  assign w_legal       = onehot_legal(w_cmd_sel);
  assign w_accept      = bus.cmd_valid && w_cmd_ready;
  assign w_done_hit    = |(bus.unit_done[NUM_OPS-1:OP_SEL_LSB] & w_lat_op[NUM_OPS-1:OP_SEL_LSB]);
  assign w_unused_done = |bus.unit_done[OP_SEL_LSB-1:0];

  rvdffe #(.WIDTH(CMD_W)) u_cmd_latch (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (w_accept),
    .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_c, bus.cmd_frm}),
    .dout  (r_cmd)
  );

  assign {w_lat_op, w_lat_a, w_lat_b, w_lat_c, w_lat_frm} = r_cmd;

  rvdffe #(.WIDTH(RSP_W)) u_rsp_latch (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (w_rsp_load),
    .din   ({w_rsp_op, w_rsp_result, w_rsp_exc, w_rsp_err}),
    .dout  (r_rsp)
  );

  fpu_op_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst_l (rst_l),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus response capture; flush beats done, and done beats timeout.
  always_comb begin
    w_next       = r_state;
    w_rsp_load   = 1'b0;
    w_rsp_op     = w_lat_op;
    w_rsp_result = '0;
    w_rsp_exc    = '0;
    w_rsp_err    = ERR_OK;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_next = ISSUE;
          end else begin
            w_next     = RESP;
            w_rsp_load = 1'b1;
            w_rsp_op   = bus.cmd_op;
            w_rsp_err  = ERR_ILLEGAL;
          end
        end
      end
      ISSUE, WAIT: begin
        if (bus.flush) begin
          w_next = IDLE;
        end else if (w_done_hit) begin
          w_next       = RESP;
          w_rsp_load   = 1'b1;
          w_rsp_result = bus.unit_result;
          w_rsp_exc    = bus.unit_exc;
          w_rsp_err    = ERR_OK;
        end else if ((r_state == WAIT) && w_tc) begin
          w_next     = RESP;
          w_rsp_load = 1'b1;
          w_rsp_err  = ERR_TIMEOUT;
        end else begin
          w_next = WAIT;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Moore-style outputs and timer control derived from the current state.
  always_comb begin
    w_cmd_ready    = (r_state == IDLE) && !bus.flush;
    w_issue_valids = (r_state == ISSUE) ? w_lat_op : '0;
    w_rsp_valid    = (r_state == RESP);
    w_busy         = (r_state != IDLE);
    w_timer_clr    = (r_state != WAIT);
    w_timer_en     = (r_state == WAIT);
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.issue_valids = w_issue_valids;
  assign bus.issue_a      = w_lat_a;
  assign bus.issue_b      = w_lat_b;
  assign bus.issue_c      = w_lat_c;
  assign bus.issue_frm    = w_lat_frm;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.busy         = w_busy;
  assign {bus.rsp_op, bus.rsp_result, bus.rsp_exc, bus.rsp_err} = r_rsp;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with an 8-cycle timeout. Stimulus
// pushes the expected issue pulses and responses (payload and cycle number);
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fpu_op_sequencer;
  import fpu_ctrl_pkg::*;

  localparam int NUM_OPS = 13;
  localparam int TMO     = 8;

  typedef struct {
    logic [NUM_OPS-1:0] op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [31:0]        c;
    logic [2:0]         frm;
    int                 cyc;
  } iss_t;

  typedef struct {
    logic [NUM_OPS-1:0] op;
    logic [31:0]        result;
    logic [4:0]         exc;
    logic [1:0]         err;
    int                 cyc;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;

  iss_t issQ[$];
  rsp_t rspQ[$];

  fpu_op_sequencer_if #(.NUM_OPS(NUM_OPS)) bus ();

  fpu_op_sequencer #(
    .NUM_OPS        (NUM_OPS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Cycle number used to time-stamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare whenever an issue pulse or response is visible.
  always @(negedge clk) begin
    iss_t ei;
    rsp_t er;
    if (bus.issue_valids != '0) begin
      total++;
      if (issQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_issue: actual op=%h at cycle %0d, required no issue", bus.issue_valids, cyc);
      end else begin
        ei = issQ.pop_front();
        if (bus.issue_valids !== ei.op || bus.issue_a !== ei.a || bus.issue_b !== ei.b ||
            bus.issue_c !== ei.c || bus.issue_frm !== ei.frm || cyc != ei.cyc) begin
          bad++;
          $display("[TB] FAIL issue: actual op=%h a=%h b=%h c=%h frm=%h cyc=%0d, required op=%h a=%h b=%h c=%h frm=%h cyc=%0d",
                   bus.issue_valids, bus.issue_a, bus.issue_b, bus.issue_c, bus.issue_frm, cyc,
                   ei.op, ei.a, ei.b, ei.c, ei.frm, ei.cyc);
        end
      end
    end
    if (bus.rsp_valid) begin
      total++;
      if (rspQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_rsp: actual op=%h err=%0d at cycle %0d, required no response", bus.rsp_op, bus.rsp_err, cyc);
      end else begin
        er = rspQ.pop_front();
        if (bus.rsp_op !== er.op || bus.rsp_result !== er.result || bus.rsp_exc !== er.exc ||
            bus.rsp_err !== er.err || cyc != er.cyc) begin
          bad++;
          $display("[TB] FAIL rsp: actual op=%h res=%h exc=%h err=%0d cyc=%0d, required op=%h res=%h exc=%h err=%0d cyc=%0d",
                   bus.rsp_op, bus.rsp_result, bus.rsp_exc, bus.rsp_err, cyc,
                   er.op, er.result, er.exc, er.err, er.cyc);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"},    64'(bus.cmd_ready),    64'd1);
    checkOutput({tag, "_busy"},         64'(bus.busy),         64'd0);
    checkOutput({tag, "_issue_valids"}, 64'(bus.issue_valids), 64'd0);
    checkOutput({tag, "_issue_a"},      64'(bus.issue_a),      64'd0);
    checkOutput({tag, "_issue_frm"},    64'(bus.issue_frm),    64'd0);
    checkOutput({tag, "_rsp_valid"},    64'(bus.rsp_valid),    64'd0);
    checkOutput({tag, "_rsp_op"},       64'(bus.rsp_op),       64'd0);
    checkOutput({tag, "_rsp_result"},   64'(bus.rsp_result),   64'd0);
    checkOutput({tag, "_rsp_exc"},      64'(bus.rsp_exc),      64'd0);
    checkOutput({tag, "_rsp_err"},      64'(bus.rsp_err),      64'd0);
  endtask

  // Present one command for one cycle in IDLE; legal ones expect an issue next cycle,
  // illegal ones expect an ILLEGAL response next cycle.
  task automatic applyStimulus(input logic [NUM_OPS-1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c,
                               input logic [2:0] frm, input bit legal);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_c     = c;
    bus.cmd_frm   = frm;
    if (legal) issQ.push_back('{op: op, a: a, b: b, c: c, frm: frm, cyc: cyc + 1});
    else       rspQ.push_back('{op: op, result: 32'h0, exc: 5'h0, err: ERR_ILLEGAL, cyc: cyc + 1});
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  // One-cycle done pulse; when it should complete the op, the OK response is expected next cycle.
  task automatic pulseDone(input logic [NUM_OPS-1:0] mask, input logic [31:0] res,
                           input logic [4:0] exc, input bit hit, input logic [NUM_OPS-1:0] op);
    bus.unit_done   = mask;
    bus.unit_result = res;
    bus.unit_exc    = exc;
    if (hit) rspQ.push_back('{op: op, result: res, exc: exc, err: ERR_OK, cyc: cyc + 1});
    step(1);
    bus.unit_done = '0;
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_c       = '0;
    bus.cmd_frm     = '0;
    bus.flush       = 1'b0;
    bus.unit_done   = '0;
    bus.unit_result = '0;
    bus.unit_exc    = '0;
    rst_l           = 1'b0;

    step(2);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_l = 1'b1;
    step(1);

    // Legal op on a 3-cycle unit.
    applyStimulus(13'h0004, 32'h3F800000, 32'h40000000, 32'h00000000, 3'd1, 1'b1);
    step(2);
    pulseDone(13'h0004, 32'h40400000, 5'h00, 1'b1, 13'h0004);
    step(1);
    @(negedge clk);
    checkOutput("hold_rsp_result", 64'(bus.rsp_result), 64'h40400000);
    checkOutput("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Illegal ops: two select bits, then no select bit.
    applyStimulus(13'h000C, 32'h1, 32'h2, 32'h3, 3'd0, 1'b0);
    step(1);
    applyStimulus(13'h0001, 32'h4, 32'h5, 32'h6, 3'd2, 1'b0);
    step(1);

    // Timeout: eight WAIT cycles with no done.
    applyStimulus(13'h0004, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 3'd3, 1'b1);
    rspQ.push_back('{op: 13'h0004, result: 32'h0, exc: 5'h0, err: ERR_TIMEOUT, cyc: cyc + TMO + 1});
    step(TMO + 2);

    // Done in the final WAIT cycle beats the timeout.
    applyStimulus(13'h0004, 32'h00000011, 32'h00000022, 32'h00000033, 3'd4, 1'b1);
    step(TMO);
    pulseDone(13'h0004, 32'hCAFEF00D, 5'h10, 1'b1, 13'h0004);
    step(1);

    // Done on modifier bits and on another unit is ignored.
    applyStimulus(13'h0004, 32'h01010101, 32'h02020202, 32'h03030303, 3'd0, 1'b1);
    step(1);
    pulseDone(13'h0003, 32'hDEAD0000, 5'h1F, 1'b0, 13'h0004);
    pulseDone(13'h0020, 32'hDEAD0001, 5'h1F, 1'b0, 13'h0004);
    step(1);
    pulseDone(13'h0004, 32'h12345678, 5'h05, 1'b1, 13'h0004);
    step(1);

    // Flush in WAIT: no response, ready right after, late done ignored.
    applyStimulus(13'h0004, 32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 3'd5, 1'b1);
    step(2);
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_wait_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.unit_done = 13'h0004;
    @(negedge clk);
    checkOutput("after_flush_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("after_flush_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    bus.unit_done = '0;
    step(2);

    // Flush in IDLE blocks acceptance for that cycle.
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 13'h0004;
    @(negedge clk);
    checkOutput("idle_flush_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    step(2);

    // Reset in WAIT: everything back to reset values, late done ignored.
    applyStimulus(13'h0004, 32'h55555555, 32'h66666666, 32'h77777777, 3'd6, 1'b1);
    step(2);
    rst_l = 1'b0;
    step(1);
    rst_l         = 1'b1;
    bus.unit_done = 13'h0004;
    @(negedge clk);
    checkResetValues("midreset");
    @(posedge clk); #1;
    bus.unit_done = '0;
    step(2);

    // Back-to-back: cmd_valid held across three commands.
    k = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 13'h0008;
    bus.cmd_a     = 32'hA1;
    bus.cmd_b     = 32'hB1;
    bus.cmd_c     = 32'hC1;
    bus.cmd_frm   = 3'd1;
    issQ.push_back('{op: 13'h0008, a: 32'hA1, b: 32'hB1, c: 32'hC1, frm: 3'd1, cyc: k + 1});
    rspQ.push_back('{op: 13'h0008, result: 32'h11111111, exc: 5'h02, err: ERR_OK, cyc: k + 2});
    step(1);
    bus.cmd_op      = 13'h0010;
    bus.cmd_a       = 32'hA2;
    bus.cmd_b       = 32'hB2;
    bus.cmd_c       = 32'hC2;
    bus.cmd_frm     = 3'd2;
    bus.unit_done   = 13'h0008;
    bus.unit_result = 32'h11111111;
    bus.unit_exc    = 5'h02;
    issQ.push_back('{op: 13'h0010, a: 32'hA2, b: 32'hB2, c: 32'hC2, frm: 3'd2, cyc: k + 4});
    step(1);
    bus.unit_done = '0;
    step(2);
    bus.cmd_op    = 13'h0007;
    bus.cmd_a     = 32'hA3;
    bus.cmd_b     = 32'hB3;
    bus.cmd_c     = 32'hC3;
    bus.cmd_frm   = 3'd3;
    step(1);
    pulseDone(13'h0010, 32'h22222222, 5'h00, 1'b1, 13'h0010);
    issQ.push_back('{op: 13'h0007, a: 32'hA3, b: 32'hB3, c: 32'hC3, frm: 3'd3, cyc: k + 8});
    step(2);
    bus.cmd_valid = 1'b0;
    step(1);
    pulseDone(13'h0004, 32'h33333333, 5'h08, 1'b1, 13'h0007);
    step(4);

    checkOutput("issue_queue_drained", 64'(issQ.size()), 64'd0);
    checkOutput("rsp_queue_drained", 64'(rspQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
